// File: rtl/para2_demux_if.sv
// Handshake bundle for the 1-to-4 word demultiplexer.
// The slave modport is the demux side; the master modport is the source and consumer side.
interface para2_demux_if #(
    parameter int WIDTH = 3
);
    logic             ivalid;
    logic             oready;
    logic [WIDTH-1:0] idata;
    logic [1:0]       ia;
    logic             iauto;
    logic [1:0]       optr;
    logic [WIDTH-1:0] oq0, oq1, oq2, oq3;
    logic             ov0, ov1, ov2, ov3;
    logic             iack0, iack1, iack2, iack3;

    modport slave (
        input  ivalid, idata, ia, iauto, iack0, iack1, iack2, iack3,
        output oready, optr, oq0, oq1, oq2, oq3, ov0, ov1, ov2, ov3
    );

    modport master (
        output ivalid, idata, ia, iauto, iack0, iack1, iack2, iack3,
        input  oready, optr, oq0, oq1, oq2, oq3, ov0, ov1, ov2, ov3
    );
endinterface

// File: rtl/para2_demux.sv
// Registered 1-to-4 word demultiplexer with per-channel valid/ack holding registers.
// The target channel comes from the external select or from an internal round-robin pointer.
module para2_demux #(
    parameter int WIDTH = 3
) (
    input  logic           iclk,
    input  logic           irst,
    para2_demux_if.slave   bus
);

    logic [WIDTH-1:0] r_q [4];
    logic [3:0]       r_v;
    logic [1:0]       r_ptr;

    logic [1:0]       w_t;
    logic [3:0]       w_ack;
    logic             w_ready;
    logic             w_acc;

    assign w_ack   = {bus.iack3, bus.iack2, bus.iack1, bus.iack0};
    assign w_t     = bus.iauto ? r_ptr : bus.ia;
    // A full channel still accepts when its consumer drains it in the same cycle.
    assign w_ready = ~r_v[w_t] | w_ack[w_t];
    assign w_acc   = bus.ivalid & w_ready;

    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int k = 0; k < 4; k++) begin
                r_q[k] <= '0;
            end
            r_v   <= '0;
            r_ptr <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_acc && (w_t == 2'(k))) begin
                    r_q[k] <= bus.idata;
                    r_v[k] <= 1'b1;
                end else if (w_ack[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
            if (w_acc && bus.iauto) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign bus.oready = w_ready;
    assign bus.optr   = r_ptr;
    assign bus.oq0    = r_q[0];
    assign bus.oq1    = r_q[1];
    assign bus.oq2    = r_q[2];
    assign bus.oq3    = r_q[3];
    assign bus.ov0    = r_v[0];
    assign bus.ov1    = r_v[1];
    assign bus.ov2    = r_v[2];
    assign bus.ov3    = r_v[3];

endmodule
